// File: rtl/rcon_sched.sv
// -----------------------------------------------------------------------------
// rcon_sched
// Round-constant and round-sequencing unit for the AES key-expansion datapath.
// Handles AES-128/192/256 through NK (4, 6, 8; Nr = NK+6). It runs forward for
// encryption key expansion and backward for on-the-fly decryption key
// inversion. It tracks the round index and the position of the 4-word
// round-key group within the NK-word key period, and reports which word of the
// current group takes the round constant.
//
// Optional build macro: RCON_SELFCHECK_EN
//   Defined   : every consumed round constant is compared against a ROM of the
//               ten standard constants. A mismatch sets ErrxSO, which stays set
//               until Start or reset.
//   Undefined : ErrxSO is tied low. No ROM or use counter is built.
//
// Ports
//   ClkxCI        in   1  clock, rising edge
//   RstxRI        in   1  asynchronous reset, active-high
//   StartxSI      in   1  begin a new schedule (samples DecxSI); wins over Next
//   DecxSI        in   1  direction: 0 = forward/encrypt, 1 = backward/decrypt
//   NextxSI       in   1  advance to the next round
//   ActivexSI     in   1  gate for RCONxDO
//   RCONxDO       out  8  round constant; 0 unless ActivexSI & RconValidxSO
//   RconValidxSO  out  1  current group contains the word that uses RCON
//   RconPosxDO    out  2  word position (0..3) of that word in the group
//   RoundxDO      out  4  current round index
//   BusyxSO       out  1  sequence running
//   LastRoundxSO  out  1  current round is the final one of the sequence
//   FinishedxSO   out  1  sequence completed
//   ErrxSO        out  1  sticky self-check error
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset; Next ignored, waiting for Start
// RUN   | sequencing rounds; Next advances round/mod/rcon
// DONE  | Next was seen in the last round; holds until Start or reset
// -----------------------------------------------------------------------------
module rcon_sched #(
  parameter int         NK   = 4,
  parameter logic [7:0] POLY = 8'h1B
) (
  input  logic       ClkxCI,
  input  logic       RstxRI,
  input  logic       StartxSI,
  input  logic       DecxSI,
  input  logic       NextxSI,
  input  logic       ActivexSI,
  output logic [7:0] RCONxDO,
  output logic       RconValidxSO,
  output logic [1:0] RconPosxDO,
  output logic [3:0] RoundxDO,
  output logic       BusyxSO,
  output logic       LastRoundxSO,
  output logic       FinishedxSO,
  output logic       ErrxSO
);

  localparam logic [3:0] NK_L          = 4'(NK);
  localparam logic [3:0] NR_L          = 4'(NK + 6);
  // (4*Nr) mod NK; zero for every legal NK, kept general for clarity
  localparam logic [3:0] MOD_BWD_START = 4'((4 * (NK + 6)) % NK);
  // constant used in the final round, the backward starting point
  localparam logic [7:0] RCON_LAST     = (NK == 4) ? 8'h36 :
                                         (NK == 6) ? 8'h80 : 8'h40;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_round, w_round_nxt;
  logic [3:0] r_mod,   w_mod_nxt;
  logic       r_dir,   w_dir_nxt;
  logic [7:0] r_rcon,  w_rcon_nxt;

  logic       w_valid;
  logic       w_last;
  logic       w_step;
  logic [3:0] w_dist;
  logic [3:0] w_mod_add;
  logic [3:0] w_mod_fwd;
  logic [3:0] w_mod_bwd;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? POLY : 8'h00);
  endfunction

  // Inverse of xtime: an odd value can only come from a reduced shift, so
  // undo the reduction and restore the shifted-out top bit.
  function automatic logic [7:0] inv_xtime(input logic [7:0] x);
    return x[0] ? (((x ^ POLY) >> 1) | 8'h80) : (x >> 1);
  endfunction

  // Distance from the group start to the next key-period boundary.
  // The group holds an RCON word when that boundary falls inside it.
  assign w_dist    = NK_L - r_mod;
  assign w_valid   = (r_round != 4'd0) && ((r_mod == 4'd0) || (w_dist <= 4'd3));
  assign w_last    = (r_state == S_RUN) &&
                     (r_dir ? (r_round == 4'd0) : (r_round == NR_L));
  assign w_step    = (r_state == S_RUN) && NextxSI && !w_last;

  assign w_mod_add = r_mod + 4'd4;
  assign w_mod_fwd = (w_mod_add >= NK_L) ? (w_mod_add - NK_L) : w_mod_add;
  assign w_mod_bwd = (r_mod >= 4'd4) ? (r_mod - 4'd4) : (r_mod + NK_L - 4'd4);

  always_ff @(posedge ClkxCI or posedge RstxRI) begin
    if (RstxRI) begin
      r_state <= S_IDLE;
      r_round <= 4'd0;
      r_mod   <= 4'd0;
      r_dir   <= 1'b0;
      r_rcon  <= 8'h01;
    end else begin
      r_state <= w_state_nxt;
      r_round <= w_round_nxt;
      r_mod   <= w_mod_nxt;
      r_dir   <= w_dir_nxt;
      r_rcon  <= w_rcon_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_round_nxt = r_round;
    w_mod_nxt   = r_mod;
    w_dir_nxt   = r_dir;
    w_rcon_nxt  = r_rcon;
    if (StartxSI) begin
      w_state_nxt = S_RUN;
      w_dir_nxt   = DecxSI;
      if (DecxSI) begin
        w_round_nxt = NR_L;
        w_mod_nxt   = MOD_BWD_START;
        w_rcon_nxt  = RCON_LAST;
      end else begin
        w_round_nxt = 4'd0;
        w_mod_nxt   = 4'd0;
        w_rcon_nxt  = 8'h01;
      end
    end else if ((r_state == S_RUN) && NextxSI) begin
      if (w_last) begin
        // final round: finish without stepping round or rcon
        w_state_nxt = S_DONE;
      end else if (r_dir) begin
        w_round_nxt = r_round - 4'd1;
        w_mod_nxt   = w_mod_bwd;
        if (w_valid) begin
          w_rcon_nxt = inv_xtime(r_rcon);
        end
      end else begin
        w_round_nxt = r_round + 4'd1;
        w_mod_nxt   = w_mod_fwd;
        if (w_valid) begin
          w_rcon_nxt = xtime(r_rcon);
        end
      end
    end
  end

  assign RconValidxSO = w_valid;
  assign RconPosxDO   = (w_valid && (r_mod != 4'd0)) ? w_dist[1:0] : 2'd0;
  assign RCONxDO      = (ActivexSI && w_valid) ? r_rcon : 8'h00;
  assign RoundxDO     = r_round;
  assign BusyxSO      = (r_state == S_RUN);
  assign LastRoundxSO = w_last;
  assign FinishedxSO  = (r_state == S_DONE);

`ifdef RCON_SELFCHECK_EN
  // index of the last standard constant used by this key length
  localparam logic [3:0] CNT_BWD_START = (NK == 4) ? 4'd9 :
                                         (NK == 6) ? 4'd7 : 4'd6;

  logic [3:0] r_use_cnt;
  logic       r_err;

  function automatic logic [7:0] rcon_rom(input logic [3:0] idx);
    logic [7:0] v;
    case (idx)
      4'd0:    v = 8'h01;
      4'd1:    v = 8'h02;
      4'd2:    v = 8'h04;
      4'd3:    v = 8'h08;
      4'd4:    v = 8'h10;
      4'd5:    v = 8'h20;
      4'd6:    v = 8'h40;
      4'd7:    v = 8'h80;
      4'd8:    v = 8'h1B;
      4'd9:    v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  always_ff @(posedge ClkxCI or posedge RstxRI) begin
    if (RstxRI) begin
      r_use_cnt <= 4'd0;
      r_err     <= 1'b0;
    end else if (StartxSI) begin
      r_use_cnt <= DecxSI ? CNT_BWD_START : 4'd0;
      r_err     <= 1'b0;
    end else if (w_step && w_valid) begin
      if (r_rcon != rcon_rom(r_use_cnt)) begin
        r_err <= 1'b1;
      end
      r_use_cnt <= r_dir ? (r_use_cnt - 4'd1) : (r_use_cnt + 4'd1);
    end
  end

  assign ErrxSO = r_err;
`else
  assign ErrxSO = 1'b0;
`endif

endmodule

// File: tb/tb_rcon_sched.sv
module tb_rcon_sched;

  logic clk = 1'b0;
  logic rst, start, dec, nxt, active;

  logic [7:0] o4_rcon, o6_rcon, o8_rcon;
  logic       o4_valid, o6_valid, o8_valid;
  logic [1:0] o4_pos, o6_pos, o8_pos;
  logic [3:0] o4_round, o6_round, o8_round;
  logic       o4_busy, o6_busy, o8_busy;
  logic       o4_last, o6_last, o8_last;
  logic       o4_fin, o6_fin, o8_fin;
  logic       o4_err, o6_err, o8_err;

  int n_cmp = 0;
  int n_bad = 0;

  // hand-computed expectations, indexed by round
  logic [7:0] exp4_rcon [0:10] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                   8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
  logic [7:0] exp6_rcon [0:12] = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h04, 8'h00, 8'h08,
                                   8'h10, 8'h00, 8'h20, 8'h40, 8'h00, 8'h80};
  logic [1:0] exp6_pos  [0:12] = '{2'd0, 2'd2, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0,
                                   2'd2, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0};
  logic       exp6_val  [0:12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                                   1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [7:0] exp8_rcon [0:14] = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h04,
                                   8'h00, 8'h08, 8'h00, 8'h10, 8'h00, 8'h20, 8'h00,
                                   8'h40};

  always #5 clk = ~clk;

  rcon_sched #(.NK(4), .POLY(8'h1B)) u_nk4 (
    .ClkxCI(clk), .RstxRI(rst), .StartxSI(start), .DecxSI(dec), .NextxSI(nxt),
    .ActivexSI(active), .RCONxDO(o4_rcon), .RconValidxSO(o4_valid),
    .RconPosxDO(o4_pos), .RoundxDO(o4_round), .BusyxSO(o4_busy),
    .LastRoundxSO(o4_last), .FinishedxSO(o4_fin), .ErrxSO(o4_err)
  );

  rcon_sched #(.NK(6), .POLY(8'h1B)) u_nk6 (
    .ClkxCI(clk), .RstxRI(rst), .StartxSI(start), .DecxSI(dec), .NextxSI(nxt),
    .ActivexSI(active), .RCONxDO(o6_rcon), .RconValidxSO(o6_valid),
    .RconPosxDO(o6_pos), .RoundxDO(o6_round), .BusyxSO(o6_busy),
    .LastRoundxSO(o6_last), .FinishedxSO(o6_fin), .ErrxSO(o6_err)
  );

  rcon_sched #(.NK(8), .POLY(8'h1B)) u_nk8 (
    .ClkxCI(clk), .RstxRI(rst), .StartxSI(start), .DecxSI(dec), .NextxSI(nxt),
    .ActivexSI(active), .RCONxDO(o8_rcon), .RconValidxSO(o8_valid),
    .RconPosxDO(o8_pos), .RoundxDO(o8_round), .BusyxSO(o8_busy),
    .LastRoundxSO(o8_last), .FinishedxSO(o8_fin), .ErrxSO(o8_err)
  );

  // inputs change on the falling edge; callers sample on the falling edge
  task automatic pulse_start(input logic d);
    @(negedge clk);
    dec   = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_next();
    @(negedge clk);
    nxt = 1'b1;
    @(negedge clk);
    nxt = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dec = 1'b0; nxt = 1'b0; active = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({o4_rcon, o4_valid, o4_pos, o4_round, o4_busy, o4_last, o4_fin, o4_err} !== 20'h0) begin
      n_bad++;
      $display("FAIL reset_nk4_outputs: got %h want 0",
               {o4_rcon, o4_valid, o4_pos, o4_round, o4_busy, o4_last, o4_fin, o4_err});
    end
    n_cmp++;
    if ({o8_rcon, o8_valid, o8_pos, o8_round, o8_busy, o8_last, o8_fin, o8_err} !== 20'h0) begin
      n_bad++;
      $display("FAIL reset_nk8_outputs: got %h want 0",
               {o8_rcon, o8_valid, o8_pos, o8_round, o8_busy, o8_last, o8_fin, o8_err});
    end
    rst = 1'b0;
    pulse_next();
    n_cmp++;
    if ({o4_round, o4_busy, o4_fin} !== 6'h0) begin
      n_bad++;
      $display("FAIL next_in_idle: got round=%0d busy=%b fin=%b want 0/0/0",
               o4_round, o4_busy, o4_fin);
    end
  endtask

  task automatic test_fwd_nk4();
    active = 1'b1;
    pulse_start(1'b0);
    for (int r = 0; r <= 10; r++) begin
      n_cmp++;
      if (o4_round !== 4'(r) || o4_busy !== 1'b1) begin
        n_bad++;
        $display("FAIL fwd4_round r=%0d: got round=%0d busy=%b", r, o4_round, o4_busy);
      end
      n_cmp++;
      if (o4_rcon !== exp4_rcon[r] || o4_pos !== 2'd0 || o4_valid !== (r != 0)) begin
        n_bad++;
        $display("FAIL fwd4_rcon r=%0d: got rcon=%h pos=%0d val=%b want rcon=%h pos=0 val=%b",
                 r, o4_rcon, o4_pos, o4_valid, exp4_rcon[r], (r != 0));
      end
      n_cmp++;
      if (o4_last !== (r == 10) || o4_err !== 1'b0) begin
        n_bad++;
        $display("FAIL fwd4_last r=%0d: got last=%b err=%b want last=%b err=0",
                 r, o4_last, o4_err, (r == 10));
      end
      if (r < 10) pulse_next();
    end
    pulse_next();
    n_cmp++;
    if (o4_fin !== 1'b1 || o4_busy !== 1'b0 || o4_round !== 4'd10 || o4_last !== 1'b0) begin
      n_bad++;
      $display("FAIL fwd4_done: got fin=%b busy=%b round=%0d last=%b want 1/0/10/0",
               o4_fin, o4_busy, o4_round, o4_last);
    end
    pulse_next();
    n_cmp++;
    if (o4_fin !== 1'b1 || o4_round !== 4'd10 || o4_rcon !== 8'h36) begin
      n_bad++;
      $display("FAIL fwd4_done_hold: got fin=%b round=%0d rcon=%h want 1/10/36",
               o4_fin, o4_round, o4_rcon);
    end
  endtask

  task automatic test_fwd_nk6();
    active = 1'b1;
    pulse_start(1'b0);
    for (int r = 0; r <= 12; r++) begin
      n_cmp++;
      if (o6_round !== 4'(r) || o6_valid !== exp6_val[r] || o6_pos !== exp6_pos[r]) begin
        n_bad++;
        $display("FAIL fwd6_valpos r=%0d: got round=%0d val=%b pos=%0d want val=%b pos=%0d",
                 r, o6_round, o6_valid, o6_pos, exp6_val[r], exp6_pos[r]);
      end
      n_cmp++;
      if (o6_rcon !== exp6_rcon[r] || o6_last !== (r == 12)) begin
        n_bad++;
        $display("FAIL fwd6_rcon r=%0d: got rcon=%h last=%b want rcon=%h last=%b",
                 r, o6_rcon, o6_last, exp6_rcon[r], (r == 12));
      end
      if (r < 12) pulse_next();
    end
    pulse_next();
    n_cmp++;
    if (o6_fin !== 1'b1 || o6_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL fwd6_done: got fin=%b busy=%b want 1/0", o6_fin, o6_busy);
    end
  endtask

  task automatic test_bwd_nk8();
    active = 1'b1;
    pulse_start(1'b1);
    n_cmp++;
    if (o4_round !== 4'd10 || o4_rcon !== 8'h36 || o6_round !== 4'd12 || o6_rcon !== 8'h80) begin
      n_bad++;
      $display("FAIL bwd_start_nk4_nk6: got r4=%0d c4=%h r6=%0d c6=%h want 10/36/12/80",
               o4_round, o4_rcon, o6_round, o6_rcon);
    end
    pulse_next();
    n_cmp++;
    if (o4_round !== 4'd9 || o4_rcon !== 8'h1B || o6_round !== 4'd11 || o6_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bwd_step_nk4_nk6: got r4=%0d c4=%h r6=%0d v6=%b want 9/1B/11/0",
               o4_round, o4_rcon, o6_round, o6_valid);
    end
    for (int r = 13; r >= 0; r--) begin
      n_cmp++;
      if (o8_round !== 4'(r) || o8_rcon !== exp8_rcon[r] || o8_pos !== 2'd0) begin
        n_bad++;
        $display("FAIL bwd8_rcon r=%0d: got round=%0d rcon=%h pos=%0d want rcon=%h pos=0",
                 r, o8_round, o8_rcon, o8_pos, exp8_rcon[r]);
      end
      n_cmp++;
      if (o8_valid !== (exp8_rcon[r] != 8'h00) || o8_last !== (r == 0) || o8_busy !== 1'b1) begin
        n_bad++;
        $display("FAIL bwd8_flags r=%0d: got val=%b last=%b busy=%b", r, o8_valid, o8_last, o8_busy);
      end
      if (r > 0) pulse_next();
    end
    pulse_next();
    n_cmp++;
    if (o8_fin !== 1'b1 || o8_busy !== 1'b0 || o8_round !== 4'd0 || o8_err !== 1'b0) begin
      n_bad++;
      $display("FAIL bwd8_done: got fin=%b busy=%b round=%0d err=%b want 1/0/0/0",
               o8_fin, o8_busy, o8_round, o8_err);
    end
  endtask

  task automatic test_active_gate();
    active = 1'b0;
    pulse_start(1'b0);
    for (int r = 0; r <= 10; r++) begin
      if (r == 5) begin
        active = 1'b1;
        #1;
        n_cmp++;
        if (o4_rcon !== 8'h10) begin
          n_bad++;
          $display("FAIL active_toggle r=5: got rcon=%h want 10", o4_rcon);
        end
        active = 1'b0;
        #1;
      end
      n_cmp++;
      if (o4_rcon !== 8'h00 || o4_round !== 4'(r)) begin
        n_bad++;
        $display("FAIL active_low r=%0d: got rcon=%h round=%0d want 00/%0d",
                 r, o4_rcon, o4_round, r);
      end
      if (r < 10) pulse_next();
    end
    active = 1'b1;
    #1;
    n_cmp++;
    if (o4_rcon !== 8'h36 || o4_last !== 1'b1) begin
      n_bad++;
      $display("FAIL active_end: got rcon=%h last=%b want 36/1", o4_rcon, o4_last);
    end
  endtask

  task automatic test_midrun_reset();
    active = 1'b1;
    pulse_start(1'b0);
    repeat (4) pulse_next();
    n_cmp++;
    if (o4_round !== 4'd4 || o4_rcon !== 8'h08) begin
      n_bad++;
      $display("FAIL midrst_pre: got round=%0d rcon=%h want 4/08", o4_round, o4_rcon);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({o4_round, o4_busy, o4_valid, o4_rcon, o4_last, o4_fin} !== 16'h0) begin
      n_bad++;
      $display("FAIL midrst_async: got round=%0d busy=%b val=%b rcon=%h last=%b fin=%b want all 0",
               o4_round, o4_busy, o4_valid, o4_rcon, o4_last, o4_fin);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (o4_fin !== 1'b0 || o4_busy !== 1'b0 || o4_round !== 4'd0) begin
      n_bad++;
      $display("FAIL midrst_idle: got fin=%b busy=%b round=%0d want 0/0/0", o4_fin, o4_busy, o4_round);
    end
  endtask

  task automatic test_start_with_next();
    active = 1'b1;
    pulse_start(1'b0);
    repeat (6) pulse_next();
    @(negedge clk);
    start = 1'b1;
    nxt   = 1'b1;
    dec   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    nxt   = 1'b0;
    n_cmp++;
    if (o4_round !== 4'd0 || o4_busy !== 1'b1 || o4_valid !== 1'b0 || o4_rcon !== 8'h00) begin
      n_bad++;
      $display("FAIL start_next: got round=%0d busy=%b val=%b rcon=%h want 0/1/0/00",
               o4_round, o4_busy, o4_valid, o4_rcon);
    end
    pulse_next();
    n_cmp++;
    if (o4_round !== 4'd1 || o4_rcon !== 8'h01) begin
      n_bad++;
      $display("FAIL start_next_step: got round=%0d rcon=%h want 1/01", o4_round, o4_rcon);
    end
  endtask

  task automatic test_selfcheck();
    active = 1'b1;
    pulse_start(1'b0);
    repeat (2) pulse_next();
`ifdef RCON_SELFCHECK_EN
    @(negedge clk);
    force u_nk4.r_rcon = 8'h03;
    nxt = 1'b1;
    @(negedge clk);
    nxt = 1'b0;
    release u_nk4.r_rcon;
    n_cmp++;
    if (o4_err !== 1'b1) begin
      n_bad++;
      $display("FAIL selfcheck_set: got err=%b want 1", o4_err);
    end
    repeat (3) pulse_next();
    n_cmp++;
    if (o4_err !== 1'b1) begin
      n_bad++;
      $display("FAIL selfcheck_sticky: got err=%b want 1", o4_err);
    end
    pulse_start(1'b0);
    n_cmp++;
    if (o4_err !== 1'b0) begin
      n_bad++;
      $display("FAIL selfcheck_clear: got err=%b want 0", o4_err);
    end
`else
    repeat (8) pulse_next();
    n_cmp++;
    if (o4_err !== 1'b0 || o6_err !== 1'b0 || o8_err !== 1'b0) begin
      n_bad++;
      $display("FAIL selfcheck_off: got err=%b%b%b want 000", o4_err, o6_err, o8_err);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_fwd_nk4();
    test_fwd_nk6();
    test_bwd_nk8();
    test_active_gate();
    test_midrun_reset();
    test_start_with_next();
    test_selfcheck();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d mismatched=%0d", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rcon_sched.md
Name: rcon_sched

Overview:
- Parametrised round-constant and round-sequencing unit for the AES key-expansion datapath. Supports AES-128, AES-192 and AES-256 through the NK parameter.
- Runs forward for encryption key expansion and backward for on-the-fly decryption key inversion.
- Tracks the round index and the 4-word round-key group. Flags the rounds, and the word position within each round, where the round constant is applied.
- Sits beside the key-schedule core and drives its RCON/S-box XOR and round control.

Parameters:
NK, 4, key length in 32-bit words; legal values 4, 6, 8. Nr = NK+6.
POLY, 8'h1B, low byte of the GF(2^8) reduction polynomial used by xtime and inverse xtime.

Ports:
ClkxCI  in  1  clock, rising edge
RstxRI  in  1  reset, asynchronous, active-high
StartxSI  in  1  begin a new schedule; samples DecxSI
DecxSI  in  1  direction, sampled with Start: 0 = forward/encrypt, 1 = backward/decrypt
NextxSI  in  1  advance to the next round
ActivexSI  in  1  gate the RCON output
RCONxDO  out  8  round constant; 0 unless ActivexSI & RconValidxSO
RconValidxSO  out  1  current round group contains a word that uses RCON
RconPosxDO  out  2  word position (0..3) in the group where RCON applies
RoundxDO  out  4  current round index
BusyxSO  out  1  high in RUN
LastRoundxSO  out  1  current round is the final round of the sequence
FinishedxSO  out  1  high in DONE
ErrxSO  out  1  self-check error, sticky (see Optional Feature)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - state = IDLE, round = 0, mod = 0, dir = 0, rcon register = 8'h01.
  - All outputs 0 except RoundxDO = 0.
- Reset asserted mid-run aborts the sequence immediately, with no completion.
- States: IDLE, RUN, DONE.
- StartxSI, in any state, moves the unit to RUN at the next edge. Start wins over a simultaneous NextxSI.
  - Forward start: round = 0, mod = 0, rcon = 8'h01.
  - Backward start: round = Nr, mod = (4*Nr) mod NK (equals 0 for all legal NK), rcon = final constant: 8'h36 for NK=4, 8'h80 for NK=6, 8'h40 for NK=8.
- Round group r covers expanded words 4r..4r+3. mod holds (4r) mod NK.
- RconValidxSO = (r != 0) & (mod == 0 | NK-mod <= 3). This is combinational from registers.
- RconPosxDO = 0 if mod == 0, else NK-mod; 0 when not valid.
- NextxSI in RUN and not the last round:
  - Forward: round+1, mod = (mod+4) mod NK.
  - Backward: round-1, mod = (mod-4) mod NK.
  - If the current round was RconValid, the rcon register steps. Forward uses xtime: (x<<1) ^ (x[7] ? POLY : 0). Backward uses inverse xtime: x[0] ? ((x^POLY)>>1)|8'h80 : x>>1.
  - Otherwise rcon holds.
- LastRoundxSO = RUN & (forward ? round == Nr : round == 0).
- NextxSI during the last round moves the unit to DONE. Round and rcon hold, with no further step.
- NextxSI in IDLE or DONE is ignored. DONE persists until Start or reset.
- Latency: every output is registered-state-derived, so a change appears the cycle after the causing edge. No combinational path from NextxSI to the outputs.
- The rcon register never reaches 0. Forward steps past the last used value are impossible because the last round does not step.

Optional Feature:
RCON_SELFCHECK_EN
- Defined:
  - A constant ROM of the 10 standard constants (POLY = 8'h1B) is indexed by a rcon-use counter. The counter starts at 0 for forward and at the count-1 for backward: 9, 7 or 6.
  - On each consuming NextxSI, if the register does not equal the ROM entry, ErrxSO sets. It is sticky until Start or reset.
  - This is fault detection on the constant path.
- Undefined: ErrxSO tied to 0, with no ROM or counter.

Test Plan:
- NK=4, forward Start, Active=1, 10 Nexts -> RCON 00 in round 0; then 01,02,04,08,10,20,40,80,1B,36 in rounds 1..10 at pos 0. LastRound high at round 10. 11th Next -> Finished=1, Busy=0.
- NK=6, forward -> Valid in rounds 1,3,4,6,7,9,10,12 with pos 2,0,2,0,2,0,2,0 and RCON 01..80. Rounds 2,5,8,11 have Valid=0.
- NK=8, backward Start -> round 14 RCON=40 pos 0, then 20 at round 12, down to 01 at round 2. Odd rounds Valid=0. LastRound at round 0.
- Active=0 throughout NK=4 run -> RCONxDO=0 every cycle; internal sequence identical, checked by toggling Active at round 5 -> RCON 10.
- Mid-run events:
  - Reset pulse at round 4 -> IDLE and outputs cleared within the same cycle (async).
  - Start with Next at round 6 -> round 0, rcon 01, no step.
- Self-check (RCON_SELFCHECK_EN): force rcon register to 8'h03 at round 2 -> ErrxSO=1 after the next Next, stays 1 until Start. Undefined -> ErrxSO=0 always.
